// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  typedef enum logic {OWN_FETCH, OWN_DATA} owner_t;

  // Width of the starvation counter; STARVE_LIMIT must fit in it.
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and backing-memory handshake signals.
// Latency: n/a (wires only).
// Backpressure: requesters wait for x_gnt; the memory stalls via mem_gnt.
interface mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  // fetch side
  logic                  i_req;
  logic [ADDR_WIDTH-1:0] i_addr;
  logic                  i_flush;
  logic                  i_gnt;
  logic                  i_rvalid;
  logic [DATA_WIDTH-1:0] i_rdata;

  // data side
  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [BE_WIDTH-1:0]   d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  // backing memory side
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Arbiter view.
  modport slave (
    input  i_req, i_addr, i_flush,
    output i_gnt, i_rvalid, i_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  // Requesters plus memory view.
  modport master (
    output i_req, i_addr, i_flush,
    input  i_gnt, i_rvalid, i_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (read-only) and data (r/w), data-priority with starvation guard.
// Latency: grant 1 cycle after request; response 1 cycle after mem_rvalid.
// Backpressure: one transaction in flight; mem_req/payload held until mem_gnt; requests ignored outside IDLE.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  state_t                  state_q, state_d;
  owner_t                  owner_q;
  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    flush_pend_q;
  logic                    i_gnt_q, d_gnt_q, i_rvalid_q, d_rvalid_q;
  logic [DATA_WIDTH-1:0]   i_rdata_q, d_rdata_q;
  logic                    mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [BE_W-1:0]         mem_be_q;

  logic fetch_elig, pick_fetch, pick_data, rsp_drop;

  // A flushed fetch request sits out the arbitration entirely.
  assign fetch_elig = bus.i_req && !bus.i_flush;

  // A fetch response is dropped if a flush hit it at any point, including the response cycle itself.
  assign rsp_drop = (owner_q == OWN_FETCH) && (flush_pend_q || bus.i_flush);

  // Winner selection: data first, unless fetch has already lost LIMIT times in a row.
  always_comb begin
    pick_fetch = 1'b0;
    pick_data  = 1'b0;
    starve_d   = starve_q;
    if (fetch_elig && bus.d_req) begin
      if (starve_q < LIMIT) begin
        pick_data = 1'b1;
        starve_d  = starve_q + 1'b1;
      end else begin
        pick_fetch = 1'b1;
        starve_d   = '0;
      end
    end else if (bus.d_req) begin
      pick_data = 1'b1;
      starve_d  = '0;
    end else if (fetch_elig) begin
      pick_fetch = 1'b1;
      starve_d   = '0;
    end
  end

  // Next-state logic for the single-outstanding transaction sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_fetch || pick_data) state_d = ISSUE;
      ISSUE:   if (bus.mem_gnt) state_d = WAIT;
      WAIT:    if (bus.mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Payload latch, grant/response pulses, starvation counter and flush tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_FETCH;
      starve_q     <= '0;
      flush_pend_q <= 1'b0;
      i_gnt_q      <= 1'b0;
      d_gnt_q      <= 1'b0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          flush_pend_q <= 1'b0;
          starve_q     <= starve_d;
          if (pick_data) begin
            owner_q     <= OWN_DATA;
            d_gnt_q     <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            mem_be_q    <= bus.d_be;
          end else if (pick_fetch) begin
            owner_q     <= OWN_FETCH;
            i_gnt_q     <= 1'b1;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.i_addr;
            mem_wdata_q <= '0;
            mem_be_q    <= '1;
          end
        end
        ISSUE: begin
          if (owner_q == OWN_FETCH && bus.i_flush) flush_pend_q <= 1'b1;
          if (bus.mem_gnt) mem_req_q <= 1'b0;
        end
        WAIT: begin
          if (owner_q == OWN_FETCH && bus.i_flush) flush_pend_q <= 1'b1;
          if (bus.mem_rvalid) begin
            flush_pend_q <= 1'b0;
            if (owner_q == OWN_DATA) begin
              d_rvalid_q <= 1'b1;
              d_rdata_q  <= mem_we_q ? '0 : bus.mem_rdata;
            end else if (!rsp_drop) begin
              i_rvalid_q <= 1'b1;
              i_rdata_q  <= bus.mem_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.i_gnt     = i_gnt_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.i_rvalid  = i_rvalid_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized phase against a transaction-level model.
// Latency: grants expected 1 cycle after request, responses 1 cycle after mem_rvalid.
// Backpressure: the bench plays the memory and stalls mem_gnt/mem_rvalid by random amounts.
module tb_mem_port_arbiter;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: consecutive data wins while fetch was waiting, requester-visible memory, last delivered data.
  int          data_streak = 0;
  logic [31:0] ref_mem  [logic [31:0]];
  logic [31:0] phys_mem [logic [31:0]];
  logic [31:0] exp_irdata = '0;
  logic [31:0] exp_drdata = '0;
  logic [31:0] addr_tab [4] = '{32'h100, 32'h104, 32'h200, 32'h2000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : dflt(a);
  endfunction

  // Grant rule: data wins unless fetch has already lost LIMIT times in a row while waiting.
  task automatic pick(input bit ir, input bit dr, output bit f);
    if (ir && dr) begin
      if (data_streak < LIMIT) begin data_streak++; f = 1'b0; end
      else begin data_streak = 0; f = 1'b1; end
    end else begin
      data_streak = 0;
      f = ir;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_i_gnt"},    bus.i_gnt, 0);
    chk({tag, "_d_gnt"},    bus.d_gnt, 0);
    chk({tag, "_i_rvalid"}, bus.i_rvalid, 0);
    chk({tag, "_d_rvalid"}, bus.d_rvalid, 0);
    chk({tag, "_i_rdata"},  bus.i_rdata, 0);
    chk({tag, "_d_rdata"},  bus.d_rdata, 0);
    chk({tag, "_mem_req"},  bus.mem_req, 0);
    chk({tag, "_mem_pay"},  {bus.mem_we, bus.mem_be, bus.mem_addr}, 0);
    chk({tag, "_mem_wd"},   bus.mem_wdata, 0);
  endtask

  // One whole transaction from the arbitration edge to the response; called at a negedge with inputs set.
  task automatic do_txn(input bit f, input int gd, input int rd, input int fc);
    logic [31:0] ea, ewd, ev, ca, cwd;
    logic        ewe, cwe;
    logic [3:0]  ebe, cbe;
    bit          drop;
    ea  = f ? bus.i_addr : bus.d_addr;
    ewe = f ? 1'b0 : bus.d_we;
    ebe = f ? 4'hF : bus.d_be;
    ewd = f ? 32'h0 : bus.d_wdata;
    ev  = ref_rd(ea);
    if (ewe) ref_mem[ea] = merge(ev, ewd, ebe);
    @(negedge clk);
    chk("i_gnt", bus.i_gnt, f);
    chk("d_gnt", bus.d_gnt, !f);
    chk("rvalid_at_gnt", {bus.i_rvalid, bus.d_rvalid}, 0);
    chk("mem_req", bus.mem_req, 1);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_we", bus.mem_we, ewe);
    chk("mem_be", bus.mem_be, ebe);
    chk("mem_wdata", bus.mem_wdata, ewd);
    // The winner is free to drop its request and change its payload now.
    if (f) begin
      bus.i_req  = 1'b0;
      bus.i_addr = $urandom;
    end else begin
      bus.d_req   = 1'b0;
      bus.d_we    = 1'($urandom);
      bus.d_addr  = $urandom;
      bus.d_wdata = $urandom;
      bus.d_be    = 4'($urandom);
    end
    for (int k = 0; k < gd; k++) begin
      @(negedge clk);
      chk("hold_req", bus.mem_req, 1);
      chk("hold_pay", {bus.mem_we, bus.mem_be, bus.mem_addr}, {ewe, ebe, ea});
      chk("hold_wdata", bus.mem_wdata, ewd);
      chk("no_dup_gnt", {bus.i_gnt, bus.d_gnt}, 0);
    end
    ca = bus.mem_addr; cwe = bus.mem_we; cbe = bus.mem_be; cwd = bus.mem_wdata;
    bus.mem_gnt = 1'b1;
    @(negedge clk);
    bus.mem_gnt = 1'b0;
    chk("req_drop", bus.mem_req, 0);
    for (int w = 0; w <= rd; w++) begin
      if (w == fc) bus.i_flush = 1'b1;
      if (w == rd) begin
        bus.mem_rvalid = 1'b1;
        if (cwe) begin
          bus.mem_rdata = $urandom;
          phys_mem[ca]  = merge(phys_rd(ca), cwd, cbe);
        end else begin
          bus.mem_rdata = phys_rd(ca);
        end
      end
      @(negedge clk);
      bus.i_flush    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (w < rd) chk("early_rvalid", {bus.i_rvalid, bus.d_rvalid, bus.mem_req}, 0);
    end
    drop = f && fc >= 0 && fc <= rd;
    if (f) begin
      if (!drop) exp_irdata = ev;
      chk("i_rvalid", bus.i_rvalid, !drop);
      chk("d_rvalid_on_fetch", bus.d_rvalid, 0);
    end else begin
      exp_drdata = ewe ? 32'h0 : ev;
      chk("d_rvalid", bus.d_rvalid, 1);
      chk("i_rvalid_on_data", bus.i_rvalid, 0);
    end
    chk("i_rdata", bus.i_rdata, exp_irdata);
    chk("d_rdata", bus.d_rdata, exp_drdata);
  endtask

  task automatic issue(input bit ir, input bit dr, input bit we, input logic [31:0] ia,
                       input logic [31:0] da, input logic [31:0] wd, input logic [3:0] be,
                       input int gd, input int rd, input int fc);
    bit f;
    bus.i_req = ir; bus.i_addr = ia;
    bus.d_req = dr; bus.d_we = we; bus.d_addr = da; bus.d_wdata = wd; bus.d_be = be;
    if (!ir && !dr) begin
      @(negedge clk);
      chk("idle_gnt", {bus.i_gnt, bus.d_gnt}, 0);
      chk("idle_mem_req", bus.mem_req, 0);
      return;
    end
    pick(ir, dr, f);
    do_txn(f, gd, rd, fc);
  endtask

  // Mutual exclusion of the two grant pulses and the two response pulses.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("one_gnt", bus.i_gnt & bus.d_gnt, 0);
      chk("one_rvalid", bus.i_rvalid & bus.d_rvalid, 0);
    end
  end

  initial begin
    bit f;
    int gd, rd, fc;
    bus.i_req = 0; bus.i_addr = 0; bus.i_flush = 0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_be = 0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;

    // Reset values, then a few idle cycles with nothing requested.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_zero("reset");
    repeat (3) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, -1);

    // Lone fetch, memory answers two cycles after accepting.
    ref_mem[32'h100] = 32'hDEADBEEF; phys_mem[32'h100] = 32'hDEADBEEF;
    issue(1, 0, 0, 32'h100, 0, 0, 0, 0, 1, -1);

    // Simultaneous fetch and data write: data first, then the waiting fetch.
    issue(1, 1, 1, 32'h104, 32'h2000, 32'h12345678, 4'b0011, 1, 0, -1);
    issue(1, 0, 0, 32'h104, 0, 0, 0, 0, 0, -1);
    // Read back the partially written word.
    issue(0, 1, 0, 0, 32'h2000, 0, 0, 0, 1, -1);

    // Fetch held, data re-requesting every time: fetch breaks through after LIMIT data wins.
    for (int k = 0; k < 11; k++)
      issue(1, 1, 1'($urandom), 32'h200, addr_tab[$urandom % 4], $urandom, 4'($urandom), 0, 0, -1);

    // Flushed fetch in WAIT: response swallowed, next fetch delivered.
    ref_mem[32'h300] = 32'hCAFEF00D; phys_mem[32'h300] = 32'hCAFEF00D;
    issue(1, 0, 0, 32'h300, 0, 0, 0, 0, 2, 0);
    issue(1, 0, 0, 32'h200, 0, 0, 0, 0, 0, -1);
    // Flush landing on the response cycle, and a flush during a data transaction.
    issue(1, 0, 0, 32'h104, 0, 0, 0, 0, 1, 1);
    issue(0, 1, 0, 0, 32'h300, 0, 0, 0, 1, 0);

    // Flush in IDLE keeps fetch out of the arbitration.
    bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.i_flush = 1'b1; bus.d_req = 1'b0;
    @(negedge clk);
    chk("idle_flush_gnt", {bus.i_gnt, bus.d_gnt, bus.mem_req}, 0);
    bus.i_flush = 1'b0;
    issue(1, 0, 0, 32'h100, 0, 0, 0, 0, 0, -1);

    // Memory stalls mem_gnt for five cycles.
    issue(0, 1, 1, 0, 32'h104, 32'h0BADF00D, 4'b1100, 5, 0, -1);

    // Reset in WAIT, stray response afterwards, then a normal data read.
    bus.i_req = 0; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h104;
    pick(0, 1, f);
    @(negedge clk);
    chk("rst_txn_d_gnt", bus.d_gnt, 1);
    bus.d_req = 0; bus.mem_gnt = 1;
    @(negedge clk);
    bus.mem_gnt = 0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_zero("mid_reset");
    exp_irdata = '0; exp_drdata = '0; data_streak = 0;
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    bus.mem_rvalid = 1'b0;
    chk("stray_rvalid", {bus.i_rvalid, bus.d_rvalid, bus.mem_req}, 0);
    chk("stray_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    issue(0, 1, 0, 0, 32'h104, 0, 0, 0, 0, -1);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      gd = int'($urandom_range(3, 0));
      rd = int'($urandom_range(3, 0));
      fc = ($urandom % 3 == 0) ? int'($urandom_range(rd, 0)) : -1;
      issue(1'($urandom), 1'($urandom), 1'($urandom), addr_tab[$urandom % 4], addr_tab[$urandom % 4],
            $urandom, 4'($urandom), gd, rd, fc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
